// File: rtl/dvi_test_pattern_gen.sv
// Purpose: RGB555 test-pattern source that tracks the CH7301C DE/HSYNC/VSYNC timing.
// Latency: 1 cycle from an active DE edge to the registered pixel on pix_data.
// Backpressure: none; the pixel stream is paced entirely by the driver's DE.
//
// Ports:
//   clk25_2      25.2 MHz pixel clock (shared with the CH7301C driver)
//   rst_n        synchronous active-low reset
//   DVI_DE       data enable, high on active pixels
//   DVI_H        horizontal sync, active-low; a sync pulse in blanking re-aligns
//                the horizontal counters
//   DVI_V        vertical sync, active-low; its falling edge starts a frame
//   pattern_sel  0 solid, 1 alternating, 2 colour bars, 3 checkerboard
//   pix_data     registered pixel {R[14:10], G[9:5], B[4:0]}
//   frame_cnt    frame counter, wraps 1023 -> 0
//
// Build option: define TPG_SCROLL_EN to scroll the checkerboard left by one
// pixel per frame.
module dvi_test_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BAR_WIDTH  = 80,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clk25_2,
  input  logic        rst_n,
  input  logic        DVI_DE,
  input  logic        DVI_H,
  input  logic        DVI_V,
  input  logic [1:0]  pattern_sel,
  output logic [14:0] pix_data,
  output logic [9:0]  frame_cnt
);

  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic [2:0] bar_idx;
  logic [6:0] bar_sub;
  logic [1:0] pat_q;
  logic       de_d;
  logic       v_d;

  logic        frame_start;
  logic        line_end;
  logic        h_resync;
  logic [1:0]  pat_eff;
  logic [9:0]  frame_nxt;
  logic [9:0]  x_eff;
  logic [9:0]  y_eff;
  logic [2:0]  bar_eff;
  logic [9:0]  xc;
  logic        chk_on;
  logic [14:0] bar_col;
  logic [14:0] pix_nxt;

  assign frame_start = v_d & ~DVI_V;
  assign line_end    = de_d & ~DVI_DE;
  // DE fall already clears the horizontal counters; the sync pulse is a
  // second chance in case a DE fall was ever lost.
  assign h_resync    = ~DVI_H & ~DVI_DE;

  always_comb begin
    frame_nxt = frame_start ? frame_cnt + 10'd1 : frame_cnt;
    // A frame start coinciding with DE must render with the new pattern at
    // the origin, so bypass the registers that are about to be loaded/cleared.
    pat_eff   = frame_start ? pattern_sel : pat_q;
    x_eff     = DVI_V ? x_cnt   : 10'd0;
    y_eff     = DVI_V ? y_cnt   : 10'd0;
    bar_eff   = DVI_V ? bar_idx : 3'd0;
`ifdef TPG_SCROLL_EN
    xc        = x_eff + frame_nxt;
`else
    xc        = x_eff;
`endif
    chk_on    = |(((xc ^ y_eff) >> CHECK_LOG2) & 10'd1);

    case (bar_eff)
      3'd0:    bar_col = 15'h7FFF;
      3'd1:    bar_col = 15'h7FE0;
      3'd2:    bar_col = 15'h03FF;
      3'd3:    bar_col = 15'h03E0;
      3'd4:    bar_col = 15'h7C1F;
      3'd5:    bar_col = 15'h7C00;
      3'd6:    bar_col = 15'h001F;
      default: bar_col = 15'h0000;
    endcase

    pix_nxt = 15'h0000;
    if (pat_eff == 2'd1) begin
      // Alternating pattern restarts from white every vertical sync and holds
      // through horizontal blanking.
      if (!DVI_V)       pix_nxt = 15'h7FFF;
      else if (DVI_DE)  pix_nxt = ~pix_data;
      else              pix_nxt = pix_data;
    end else if (DVI_DE) begin
      case (pat_eff)
        2'd0:    pix_nxt = 15'h7FFF;
        2'd2:    pix_nxt = bar_col;
        default: pix_nxt = chk_on ? 15'h7FFF : 15'h0000;
      endcase
    end
  end

  always_ff @(posedge clk25_2) begin
    if (!rst_n) begin
      pix_data  <= 15'h7FFF;
      frame_cnt <= 10'd0;
      x_cnt     <= 10'd0;
      y_cnt     <= 10'd0;
      bar_idx   <= 3'd0;
      bar_sub   <= 7'd0;
      pat_q     <= 2'd0;
      de_d      <= 1'b0;
      v_d       <= 1'b1;
    end else begin
      de_d      <= DVI_DE;
      v_d       <= DVI_V;
      pix_data  <= pix_nxt;
      frame_cnt <= frame_nxt;
      if (frame_start) pat_q <= pattern_sel;

      if (!DVI_V) begin
        x_cnt   <= 10'd0;
        y_cnt   <= 10'd0;
        bar_idx <= 3'd0;
        bar_sub <= 7'd0;
      end else if (DVI_DE) begin
        if (x_cnt != 10'(H_ACTIVE - 1)) x_cnt <= x_cnt + 10'd1;
        if (bar_sub == 7'(BAR_WIDTH - 1)) begin
          bar_sub <= 7'd0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_sub <= bar_sub + 7'd1;
        end
      end else if (line_end) begin
        x_cnt   <= 10'd0;
        bar_idx <= 3'd0;
        bar_sub <= 7'd0;
        if (y_cnt != 10'(V_ACTIVE - 1)) y_cnt <= y_cnt + 10'd1;
      end else if (h_resync) begin
        x_cnt   <= 10'd0;
        bar_idx <= 3'd0;
        bar_sub <= 7'd0;
      end
    end
  end

endmodule
